// File: rtl/mmm_arb_pkg.sv
// Shared defaults and helpers for the multiplier arbiter.
package mmm_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int IDW_DEF       = 256;
  localparam int ODW_DEF       = 522;
  localparam int LAT_DEF       = 4;
  localparam int RSP_DEPTH_DEF = 8;

  // Ceiling log2, usable in parameter and port width expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Width of one response FIFO entry {id, data}.
  function automatic int rsp_width(input int id_w, input int d_w);
    return id_w + d_w;
  endfunction

  // Response entry layout for the default configuration.
  typedef struct packed {
    logic [clog2(NREQ_DEF)-1:0] id;
    logic [ODW_DEF-1:0]         data;
  } rsp_t;

endpackage

// File: rtl/mmm_arb_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count.
// The head entry is visible on pop_data whenever the FIFO is non-empty;
// pop_data reads as zero when empty.
module mmm_arb_fifo
  import mmm_arb_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_pop;

  // Pointer advance; an extra wrap bit distinguishes full from empty.
  always_comb begin
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // Status flags and head read.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are only observable through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmm_mult_arb.sv
// Round-robin arbiter sharing one pipelined multiplier between NREQ
// requesters, with a tag shadow pipe and credit-protected response FIFO.
// Optional macro MMM_ARB_STAT_EN adds grant and credit-stall counters.
module mmm_mult_arb
  import mmm_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int IDW       = IDW_DEF,
  parameter int ODW       = ODW_DEF,
  parameter int LAT       = LAT_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF,
  parameter int IDW_ID    = clog2(NREQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*IDW-1:0]  i_req_a,
  input  logic [NREQ*IDW-1:0]  i_req_b,
  output logic [IDW-1:0]       o_mul_a,
  output logic [IDW-1:0]       o_mul_b,
  input  logic [ODW-1:0]       i_mul_res,
`ifdef MMM_ARB_STAT_EN
  output logic [31:0]          o_stat_issue,
  output logic [31:0]          o_stat_stall,
`endif
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [IDW_ID-1:0]    o_rsp_id,
  output logic [ODW-1:0]       o_rsp_data
);

  localparam int RSP_W = rsp_width(IDW_ID, ODW);
  localparam int CW    = clog2(RSP_DEPTH + 1);
  localparam int FCW   = clog2(RSP_DEPTH) + 1;

  logic [IDW_ID-1:0]           rr_q, rr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IDW-1:0]              mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [LAT:0]                shv_q, shv_d;
  logic [LAT:0][IDW_ID-1:0]    shid_q, shid_d;

  logic [2*NREQ-1:0]           dbl_valid;
  logic [NREQ-1:0]             rot_valid;
  logic [IDW_ID-1:0]           win_off;
  logic [IDW_ID:0]             win_sum;
  logic [IDW_ID-1:0]           win_id;
  logic                        win_found;
  logic                        credit_ok;
  logic                        issue;
  logic                        push;
  logic                        pop;
  logic [RSP_W-1:0]            push_data;
  logic [RSP_W-1:0]            head_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [FCW-1:0]              fifo_count;

  // Round-robin search: rotate valids so the pointer sits at bit 0, take the
  // lowest set bit, then map the offset back to a requester id.
  always_comb begin
    dbl_valid = {i_req_valid, i_req_valid} >> rr_q;
    rot_valid = dbl_valid[NREQ-1:0];
    win_found = |rot_valid;
    win_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) win_off = IDW_ID'(i);
    end
    win_sum = {1'b0, rr_q} + {1'b0, win_off};
    if (win_sum >= (IDW_ID+1)'(NREQ)) win_sum = win_sum - (IDW_ID+1)'(NREQ);
    win_id = win_sum[IDW_ID-1:0];
  end

  // Grant only when a credit is free; ready is one-hot for the winner.
  always_comb begin
    credit_ok   = (cnt_q < CW'(RSP_DEPTH));
    issue       = win_found & credit_ok;
    o_req_ready = issue ? (NREQ'(1) << win_id) : '0;
  end

  // Next-state for pointer, operands, shadow pipe and credit count.
  always_comb begin
    rr_d = rr_q;
    if (issue) rr_d = (win_id == IDW_ID'(NREQ - 1)) ? '0 : win_id + IDW_ID'(1);

    mul_a_d = issue ? i_req_a[win_id*IDW +: IDW] : '0;
    mul_b_d = issue ? i_req_b[win_id*IDW +: IDW] : '0;

    // Stage LAT lines up with the product of the operands registered LAT+1
    // edges earlier, i.e. LAT cycles after they were driven.
    shv_d     = {shv_q[LAT-1:0], issue};
    shid_d[0] = issue ? win_id : '0;
    for (int k = 1; k <= LAT; k++) shid_d[k] = shid_q[k-1];

    pop = ~fifo_empty & i_rsp_ready;
    unique case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards all in-flight work.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rr_q    <= '0;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      shv_q   <= '0;
      shid_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      shv_q   <= shv_d;
      shid_q  <= shid_d;
    end
  end

  assign push      = shv_q[LAT];
  assign push_data = {shid_q[LAT], i_mul_res};

  mmm_arb_fifo #(
    .W     (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (i_clk),
    .rst_n     (i_rstn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign o_mul_a                = mul_a_q;
  assign o_mul_b                = mul_b_q;
  assign o_rsp_valid            = ~fifo_empty;
  assign {o_rsp_id, o_rsp_data} = head_data;

`ifdef MMM_ARB_STAT_EN
  logic [31:0] stat_issue_q, stat_issue_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Grant count and cycles lost to exhausted credits; both wrap.
  always_comb begin
    stat_issue_d = stat_issue_q + {31'b0, issue};
    stat_stall_d = stat_stall_q + {31'b0, win_found & ~credit_ok};
  end

  // Statistic registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_issue_q <= stat_issue_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign o_stat_issue = stat_issue_q;
  assign o_stat_stall = stat_stall_q;
`endif

  // The credit count bounds FIFO occupancy, so a push never meets a full FIFO.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(push && fifo_full && !pop));
  a_credit_bound: assert property (@(posedge i_clk) disable iff (!i_rstn)
    int'(fifo_count) <= int'(cnt_q));

endmodule

// File: tb/tb_mmm_mult_arb.sv
// Self-checking bench for mmm_mult_arb with a scoreboard queue and a
// behavioural arbitration/credit model.
module tb_mmm_mult_arb;

  localparam int NREQ      = 4;
  localparam int IDW       = 256;
  localparam int ODW       = 522;
  localparam int LAT       = 4;
  localparam int RSP_DEPTH = 8;
  localparam int IDW_ID    = 2;

  typedef struct packed {
    logic [IDW_ID-1:0] id;
    logic [ODW-1:0]    data;
  } exp_t;

  logic                i_clk = 1'b0;
  logic                i_rstn;
  logic [NREQ-1:0]     i_req_valid;
  logic [NREQ-1:0]     o_req_ready;
  logic [NREQ*IDW-1:0] i_req_a;
  logic [NREQ*IDW-1:0] i_req_b;
  logic [IDW-1:0]      o_mul_a;
  logic [IDW-1:0]      o_mul_b;
  logic [ODW-1:0]      i_mul_res;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [IDW_ID-1:0]   o_rsp_id;
  logic [ODW-1:0]      o_rsp_data;
`ifdef MMM_ARB_STAT_EN
  logic [31:0]         o_stat_issue;
  logic [31:0]         o_stat_stall;
`endif

  mmm_mult_arb #(
    .NREQ(NREQ), .IDW(IDW), .ODW(ODW), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH), .IDW_ID(IDW_ID)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .i_mul_res   (i_mul_res),
`ifdef MMM_ARB_STAT_EN
    .o_stat_issue(o_stat_issue),
    .o_stat_stall(o_stat_stall),
`endif
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data)
  );

  always #5 i_clk = ~i_clk;

  // Multiplier core stand-in: LAT register stages, no reset, no stall.
  logic [ODW-1:0] mp [LAT];
  always @(posedge i_clk) begin
    mp[0] <= ODW'(o_mul_a) * ODW'(o_mul_b);
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign i_mul_res = mp[LAT-1];

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   glog[$];
  int   grant_cnt = 0;
  int   rsp_pops  = 0;

  always @(posedge i_clk) cyc++;

  task automatic check(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model of arbitration and credits, evaluated once per cycle.
  int             m_ptr = 0;
  int             m_out = 0;
  int             m_win;
  logic [NREQ-1:0] m_rdy;
  logic [IDW-1:0] m_a, m_b;
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      m_ptr = 0;
      m_out = 0;
      exp_q.delete();
    end else begin
      m_win = -1;
      m_rdy = '0;
      if (m_out < RSP_DEPTH) begin
        for (int i = 0; i < NREQ; i++)
          if (m_win < 0 && i_req_valid[(m_ptr + i) % NREQ]) m_win = (m_ptr + i) % NREQ;
      end
      if (m_win >= 0) m_rdy[m_win] = 1'b1;
      check("req_ready", o_req_ready, m_rdy);
      if (m_win >= 0) begin
        m_a = i_req_a[m_win*IDW +: IDW];
        m_b = i_req_b[m_win*IDW +: IDW];
        exp_q.push_back({IDW_ID'(m_win), ODW'(m_a) * ODW'(m_b)});
        glog.push_back(m_win);
        grant_cnt++;
        m_ptr = (m_win + 1) % NREQ;
        m_out++;
      end
      if (o_rsp_valid && i_rsp_ready) m_out--;
    end
  end

  // Response monitor: compare the FIFO head against the scoreboard.
  exp_t mon_e;
  always @(negedge i_clk) begin
    if (i_rstn && o_rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rsp_unexpected: got id %0d data %0h expected none", o_rsp_id, o_rsp_data);
      end else begin
        mon_e = exp_q[0];
        check("rsp_id", o_rsp_id, mon_e.id);
        check("rsp_data", o_rsp_data, mon_e.data);
        if (i_rsp_ready) begin
          void'(exp_q.pop_front());
          rsp_pops++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [IDW-1:0] rnd_op();
    logic [IDW-1:0] r;
    for (int i = 0; i < IDW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rnd_all();
    for (int k = 0; k < NREQ; k++) begin
      i_req_a[k*IDW +: IDW] = rnd_op();
      i_req_b[k*IDW +: IDW] = rnd_op();
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_rsp_valid) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("FAIL %s_drain: got %0d pending expected 0", nm, exp_q.size());
    end
    tick();
  endtask

  int found, g, lat, g0, p0, n_valid;
`ifdef MMM_ARB_STAT_EN
  logic [31:0] si0, st0;
`endif

  initial begin
    i_rstn      = 1'b0;
    i_req_valid = '0;
    i_req_a     = '0;
    i_req_b     = '0;
    i_rsp_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_mul_a", o_mul_a, 0);
    check("rst_rsp_data", o_rsp_data, 0);
    check("rst_rsp_id", o_rsp_id, 0);
`ifdef MMM_ARB_STAT_EN
    check("rst_stat_issue", o_stat_issue, 0);
`endif
    @(posedge i_clk);
    #1 i_rstn = 1'b1;

    // 1: single request, latency
    i_req_a[0 +: IDW] = 3;
    i_req_b[0 +: IDW] = 5;
    i_req_valid = 4'b0001;
    found = 0;
    g = 0;
    for (int n = 0; n < 5 && found == 0; n++) begin
      @(negedge i_clk);
      if (o_req_ready[0]) begin found = 1; g = cyc + 1; end
    end
    check("s1_granted", found, 1);
    tick();
    i_req_valid = '0;
    found = 0;
    lat = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin found = 1; lat = cyc - g; end
    end
    check("s1_rsp_seen", found, 1);
    check("s1_latency", lat, LAT + 1);
    check("s1_data", o_rsp_data, 15);
    check("s1_id", o_rsp_id, 0);
    drain("s1");

    // 2: all requesters valid, round robin at full rate, including max operands
    glog.delete();
    i_req_valid = '1;
    for (int c = 0; c < 24; c++) begin
      rnd_all();
      if (c == 0) begin
        i_req_a = '1;
        i_req_b = '1;
      end
      tick();
    end
    i_req_valid = '0;
    drain("s2");
    check("s2_grant_count", glog.size(), 24);
    check("s2_first", glog[0], 1);
    for (int i = 1; i < glog.size(); i++)
      check("s2_rr_order", glog[i], (glog[i-1] + 1) % NREQ);

    // 3/6: responses blocked, credits run out, then drain and resume
    glog.delete();
    g0 = grant_cnt;
    @(negedge i_clk);
`ifdef MMM_ARB_STAT_EN
    si0 = o_stat_issue;
`endif
    tick();
    i_rsp_ready = 1'b0;
    i_req_valid = '1;
    for (int c = 0; c < 14; c++) begin
      rnd_all();
      tick();
    end
    @(negedge i_clk);
    check("s3_grants", grant_cnt - g0, 8);
    check("s3_ready_stalled", o_req_ready, 0);
    check("s3_rsp_valid_held", o_rsp_valid, 1);
`ifdef MMM_ARB_STAT_EN
    check("s6_stat_issue", o_stat_issue - si0, 8);
    st0 = o_stat_stall;
    repeat (3) tick();
    @(negedge i_clk);
    check("s6_stat_stall", o_stat_stall, st0 + 32'd3);
`endif
    tick();
    p0 = rsp_pops;
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rnd_all();
      tick();
    end
    i_req_valid = '0;
    drain("s3");
    check("s3_resumed", (grant_cnt - g0) > 8, 1);
    check("s3_all_returned", rsp_pops - p0, grant_cnt - g0);

    // 4: pointer advances past the lone winner
    glog.delete();
    i_req_valid = 4'b0100;
    tick();
    i_req_valid = 4'b1010;
    tick();
    i_req_valid = 4'b0010;
    tick();
    i_req_valid = '0;
    drain("s4");
    check("s4_count", glog.size(), 3);
    if (glog.size() == 3) begin
      check("s4_g0", glog[0], 2);
      check("s4_g1", glog[1], 3);
      check("s4_g2", glog[2], 1);
    end

    // 5: reset with work in flight and in the FIFO
    i_rsp_ready = 1'b0;
    i_req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      rnd_all();
      tick();
    end
    i_req_valid = '0;
    repeat (2) tick();
    @(negedge i_clk);
    check("s5_fifo_busy", o_rsp_valid, 1);
    tick();
    i_rstn = 1'b0;
    #1;
    check("s5_rst_rsp_valid", o_rsp_valid, 0);
    check("s5_rst_mul_a", o_mul_a, 0);
    tick();
    i_rstn = 1'b1;
    i_rsp_ready = 1'b1;
    n_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid) n_valid++;
    end
    check("s5_no_stale", n_valid, 0);
    tick();
    p0 = rsp_pops;
    i_req_a[0 +: IDW] = rnd_op();
    i_req_b[0 +: IDW] = rnd_op();
    i_req_valid = 4'b0001;
    tick();
    i_req_valid = '0;
    drain("s5");
    check("s5_fresh_rsp", rsp_pops - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
